// File: rtl/tsc_mem_responder_pkg.sv
// tsc_mem_responder_pkg: shared state/op encodings and default latency for the TSC memory responder
package tsc_mem_responder_pkg;

    typedef enum logic [1:0] {
        MEMST_IDLE = 2'd0,
        MEMST_WAIT = 2'd1,
        MEMST_RESP = 2'd2
    } memst_t;

    typedef enum logic [1:0] {
        MEMOP_IFETCH = 2'd0,
        MEMOP_LOAD   = 2'd1,
        MEMOP_STORE  = 2'd2
    } memop_t;

    localparam int MEM_DEFAULT_LATENCY = 2;

endpackage

// File: rtl/tsc_mem_responder_if.sv
// tsc_mem_responder_if: CPU-side fetch/load/store request bus; master is the CPU, slave the responder
interface tsc_mem_responder_if #(
    parameter int WORD_W = 16
);
    logic              i_mem_read;
    logic [WORD_W-1:0] i_address;
    logic [WORD_W-1:0] i_data;
    logic              i_ready;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [WORD_W-1:0] d_address;
    logic [WORD_W-1:0] d_wdata;
    logic [WORD_W-1:0] d_rdata;
    logic              d_ready;
    logic              busy;
    logic              proto_err;

    modport master (
        output i_mem_read, i_address, d_mem_read, d_mem_write, d_address, d_wdata,
        input  i_data, i_ready, d_rdata, d_ready, busy, proto_err
    );

    modport slave (
        input  i_mem_read, i_address, d_mem_read, d_mem_write, d_address, d_wdata,
        output i_data, i_ready, d_rdata, d_ready, busy, proto_err
    );
endinterface

// File: rtl/tsc_mem_array.sv
// tsc_mem_array: single-port DEPTH x WORD_W word array, synchronous write, asynchronous read
module tsc_mem_array #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]        wdata,
    output logic [WORD_W-1:0]        rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/tsc_mem_responder.sv
// tsc_mem_responder: fixed-latency fetch/load/store responder for the TSC CPU over one word array
// Optional MEM_ACCESS_COUNT_EN adds per-type access counters i_cnt/d_rd_cnt/d_wr_cnt.
module tsc_mem_responder
    import tsc_mem_responder_pkg::*;
#(
    parameter int WORD_W  = 16,
    parameter int DEPTH   = 256,
    parameter int LATENCY = MEM_DEFAULT_LATENCY
) (
    input  logic               clk,
    input  logic               reset_n,
    tsc_mem_responder_if.slave bus
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [WORD_W-1:0]  i_cnt,
    output logic [WORD_W-1:0]  d_rd_cnt,
    output logic [WORD_W-1:0]  d_wr_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    memst_t            state, state_n;
    memop_t            op, op_n;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] rdata;
    logic              accept;
    logic              resp;
    logic              proto_q;
    logic              unused_hi;

    always_comb begin
        accept  = state == MEMST_IDLE && (bus.d_mem_write || bus.d_mem_read || bus.i_mem_read);
        op_n    = bus.d_mem_write ? MEMOP_STORE : bus.d_mem_read ? MEMOP_LOAD : MEMOP_IFETCH;
        // WAIT spans LATENCY-1 cycles; leaving at cnt==1 lands the counter on 0 in RESP
        state_n = state == MEMST_IDLE ? (accept ? (LATENCY == 1 ? MEMST_RESP : MEMST_WAIT) : MEMST_IDLE) :
                  state == MEMST_WAIT ? (cnt == 4'd1 ? MEMST_RESP : MEMST_WAIT) : MEMST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= MEMST_IDLE;
            op      <= MEMOP_IFETCH;
            cnt     <= '0;
            idx     <= '0;
            wdata_q <= '0;
            proto_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                op      <= op_n;
                cnt     <= 4'(LATENCY - 1);
                idx     <= op_n == MEMOP_IFETCH ? bus.i_address[AW-1:0] : bus.d_address[AW-1:0];
                wdata_q <= bus.d_wdata;
                if (bus.d_mem_write && bus.d_mem_read) proto_q <= 1'b1;
            end else if (state == MEMST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign resp          = state == MEMST_RESP;
    assign bus.busy      = state != MEMST_IDLE;
    assign bus.proto_err = proto_q;
    assign bus.i_ready   = resp && op == MEMOP_IFETCH;
    assign bus.d_ready   = resp && op != MEMOP_IFETCH;
    assign bus.i_data    = bus.i_ready ? rdata : '0;
    assign bus.d_rdata   = resp && op == MEMOP_LOAD ? rdata : '0;
    // Upper address bits alias onto the array index by design
    assign unused_hi     = ^{bus.i_address[WORD_W-1:AW], bus.d_address[WORD_W-1:AW]};

    // Gating with reset_n keeps a store aborted by reset in its RESP cycle from committing
    tsc_mem_array #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (resp && op == MEMOP_STORE && reset_n),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (rdata)
    );

`ifdef MEM_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_cnt    <= '0;
            d_rd_cnt <= '0;
            d_wr_cnt <= '0;
        end else if (resp) begin
            i_cnt    <= i_cnt + WORD_W'(op == MEMOP_IFETCH);
            d_rd_cnt <= d_rd_cnt + WORD_W'(op == MEMOP_LOAD);
            d_wr_cnt <= d_wr_cnt + WORD_W'(op == MEMOP_STORE);
        end
    end
`endif
endmodule

// File: tb/tb_tsc_mem_responder.sv
// tb_tsc_mem_responder: directed stimulus with queued expectations checked by a ready-driven monitor
module tb_tsc_mem_responder;
    localparam int LAT = 2;

    typedef struct {
        logic [15:0] data;
        bit          chk;
        int          at;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t iq[$];
    exp_t dq[$];

    tsc_mem_responder_if #(.WORD_W(16)) bus();

`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] i_cnt, d_rd_cnt, d_wr_cnt;
`endif

    tsc_mem_responder #(
        .WORD_W  (16),
        .DEPTH   (256),
        .LATENCY (LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .i_cnt    (i_cnt),
        .d_rd_cnt (d_rd_cnt),
        .d_wr_cnt (d_wr_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n) begin
            if (bus.i_ready) begin
                if (iq.size() == 0) cmp("i_ready_unexpected", 1, 0);
                else begin
                    e = iq.pop_front();
                    cmp("i_ready_cycle", cyc, e.at);
                    cmp("i_data", {16'h0, bus.i_data}, {16'h0, e.data});
                end
            end else cmp("i_data_idle", {16'h0, bus.i_data}, 0);
            if (bus.d_ready) begin
                if (dq.size() == 0) cmp("d_ready_unexpected", 1, 0);
                else begin
                    e = dq.pop_front();
                    cmp("d_ready_cycle", cyc, e.at);
                    if (e.chk) cmp("d_rdata", {16'h0, bus.d_rdata}, {16'h0, e.data});
                end
            end else cmp("d_rdata_idle", {16'h0, bus.d_rdata}, 0);
        end
    end

    // Raised on a negedge while idle; dly is the expected cycle offset of i_ready
    task automatic i_req(input logic [15:0] addr, input logic [15:0] exp_d, input int dly);
        bit seen = 0;
        bus.i_mem_read = 1'b1;
        bus.i_address  = addr;
        iq.push_back('{exp_d, 1'b1, cyc + dly});
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.i_ready;
        end
        if (!seen) cmp("i_ready_timeout", 0, 1);
        bus.i_mem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic d_req(input logic wr, input logic rd, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp_d, input bit chk);
        bit seen = 0;
        bus.d_mem_write = wr;
        bus.d_mem_read  = rd;
        bus.d_address   = addr;
        bus.d_wdata     = wd;
        dq.push_back('{exp_d, chk, cyc + LAT});
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = bus.d_ready;
        end
        if (!seen) cmp("d_ready_timeout", 0, 1);
        bus.d_mem_write = 1'b0;
        bus.d_mem_read  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.i_mem_read  = 1'b0;
        bus.i_address   = '0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        bus.d_address   = '0;
        bus.d_wdata     = '0;
        repeat (2) @(negedge clk);
        cmp("rst_busy", bus.busy, 0);
        cmp("rst_i_ready", bus.i_ready, 0);
        cmp("rst_d_ready", bus.d_ready, 0);
        cmp("rst_proto_err", bus.proto_err, 0);
        cmp("rst_i_data", bus.i_data, 0);
        cmp("rst_d_rdata", bus.d_rdata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        d_req(1, 0, 16'h0010, 16'h6A01, 16'h0, 0);
        i_req(16'h0010, 16'h6A01, LAT);
        d_req(1, 0, 16'h0020, 16'hBEEF, 16'h0, 0);
        d_req(0, 1, 16'h0020, 16'h0, 16'hBEEF, 1);

        // Simultaneous fetch and load: load wins, fetch follows after the idle cycle
        fork
            i_req(16'h0010, 16'h6A01, 2 * LAT + 1);
            d_req(0, 1, 16'h0020, 16'h0, 16'hBEEF, 1);
        join

        d_req(1, 0, 16'h0140, 16'h1111, 16'h0, 0);
        d_req(0, 1, 16'h0040, 16'h0, 16'h1111, 1);
        i_req(16'hFF40, 16'h1111, LAT);

        d_req(1, 0, 16'h0005, 16'h0055, 16'h0, 0);
        bus.d_mem_write = 1'b1;
        bus.d_address   = 16'h0005;
        bus.d_wdata     = 16'h1234;
        @(negedge clk);
        cmp("wait_busy", bus.busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        cmp("abort_busy", bus.busy, 0);
        cmp("abort_d_ready", bus.d_ready, 0);
        bus.d_mem_write = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        d_req(0, 1, 16'h0005, 16'h0, 16'h0055, 1);

        d_req(1, 1, 16'h0030, 16'hCAFE, 16'h0, 0);
        cmp("proto_set", bus.proto_err, 1);
        d_req(0, 1, 16'h0030, 16'h0, 16'hCAFE, 1);
        i_req(16'h0010, 16'h6A01, LAT);
        cmp("proto_sticky", bus.proto_err, 1);
        do_reset();
        cmp("proto_cleared", bus.proto_err, 0);

        repeat (3) i_req(16'h0010, 16'h6A01, LAT);
        d_req(1, 0, 16'h0050, 16'h7777, 16'h0, 0);
        d_req(1, 0, 16'h0051, 16'h8888, 16'h0, 0);
        d_req(0, 1, 16'h0050, 16'h0, 16'h7777, 1);
`ifdef MEM_ACCESS_COUNT_EN
        cmp("i_cnt", i_cnt, 3);
        cmp("d_rd_cnt", d_rd_cnt, 1);
        cmp("d_wr_cnt", d_wr_cnt, 2);
`endif
        repeat (3) @(negedge clk);
        cmp("iq_drained", iq.size(), 0);
        cmp("dq_drained", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
